// File: rtl/conv_seq_ctrl.sv
// Time-multiplexed strided 2-D convolution sequencer: one MAC walks every output
// window, reading taps from external synchronous memories and emitting Q16.15 results.
module conv_seq_ctrl #(
    parameter int input_size  = 7,
    parameter int filter_size = 5,
    parameter int stride      = 2,
    parameter logic signed [31:0] bias = 32'sh0,
    localparam int OUT = (input_size - filter_size) / stride + 1,
    localparam int IAW = (input_size * input_size > 1) ? $clog2(input_size * input_size) : 1,
    localparam int FAW = (filter_size * filter_size > 1) ? $clog2(filter_size * filter_size) : 1,
    localparam int OAW = (OUT * OUT > 1) ? $clog2(OUT * OUT) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [IAW-1:0] in_addr,
    input  logic [31:0]    in_data,
    output logic [FAW-1:0] flt_addr,
    input  logic [31:0]    flt_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [31:0]    out_data,
    output logic [OAW-1:0] out_addr
);

    localparam int KW = $clog2(filter_size + 1);
    localparam int CW = $clog2(OUT + 1);
    localparam logic [FAW-1:0] LAST_K  = FAW'(filter_size * filter_size - 1);
    localparam logic [KW-1:0]  LAST_KC = KW'(filter_size - 1);
    localparam logic [CW-1:0]  LAST_RC = CW'(OUT - 1);
    localparam logic signed [48:0] SAT_MAX = 49'sh0_7FFF_FFFF;
    localparam logic signed [48:0] SAT_MIN = -49'sh0_8000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [FAW-1:0]      k_q, k_d;
    logic [KW-1:0]       kr_q, kr_d;
    logic [KW-1:0]       kc_q, kc_d;
    logic [CW-1:0]       r_q, r_d;
    logic [CW-1:0]       c_q, c_d;
    logic signed [47:0]  acc_q, acc_d;
    logic                tap_vld_q, tap_vld_d;
    logic [IAW-1:0]      in_addr_q, in_addr_d;
    logic [FAW-1:0]      flt_addr_q, flt_addr_d;
    logic [OAW-1:0]      out_addr_q, out_addr_d;
    logic [31:0]         out_data_q, out_data_d;

    function automatic logic [IAW-1:0] in_addr_f(input logic [CW-1:0] r, input logic [CW-1:0] c,
                                                 input logic [KW-1:0] kr, input logic [KW-1:0] kc);
        return IAW'((32'(r) * 32'(stride) + 32'(kr)) * 32'(input_size)
                    + 32'(c) * 32'(stride) + 32'(kc));
    endfunction

    function automatic logic [OAW-1:0] out_idx_f(input logic [CW-1:0] r, input logic [CW-1:0] c);
        return OAW'(32'(r) * 32'(OUT) + 32'(c));
    endfunction

    // Full-precision product rescaled back to Q.15; upper bits beyond the accumulator are dropped.
    function automatic logic signed [47:0] tap_f(input logic signed [31:0] a, input logic signed [31:0] b);
        logic signed [63:0] p;
        p = 64'(a) * 64'(b);
        return 48'(p >>> 15);
    endfunction

    function automatic logic [31:0] sat32_f(input logic signed [47:0] acc, input logic signed [31:0] b);
        logic signed [48:0] s;
        s = 49'(acc) + 49'(b);
        if (s > SAT_MAX) begin
            return 32'h7FFF_FFFF;
        end else if (s < SAT_MIN) begin
            return 32'h8000_0000;
        end
        return s[31:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            kr_q       <= '0;
            kc_q       <= '0;
            r_q        <= '0;
            c_q        <= '0;
            acc_q      <= '0;
            tap_vld_q  <= 1'b0;
            in_addr_q  <= '0;
            flt_addr_q <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            kr_q       <= kr_d;
            kc_q       <= kc_d;
            r_q        <= r_d;
            c_q        <= c_d;
            acc_q      <= acc_d;
            tap_vld_q  <= tap_vld_d;
            in_addr_q  <= in_addr_d;
            flt_addr_q <= flt_addr_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        kr_d       = kr_q;
        kc_d       = kc_q;
        r_d        = r_q;
        c_d        = c_q;
        acc_d      = acc_q;
        in_addr_d  = in_addr_q;
        flt_addr_d = flt_addr_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        out_valid  = (state_q == S_OUT);
        // Memory data lags the address by one cycle, so the tap is consumed one cycle late.
        tap_vld_d  = (state_q == S_RUN);
        if (tap_vld_q) begin
            acc_d = acc_q + tap_f($signed(in_data), $signed(flt_data));
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    k_d        = '0;
                    kr_d       = '0;
                    kc_d       = '0;
                    r_d        = '0;
                    c_d        = '0;
                    acc_d      = '0;
                    flt_addr_d = '0;
                    in_addr_d  = in_addr_f('0, '0, '0, '0);
                end
            end
            S_RUN: begin
                if (k_q == LAST_K) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                    if (kc_q == LAST_KC) begin
                        kc_d = '0;
                        kr_d = kr_q + 1'b1;
                    end else begin
                        kc_d = kc_q + 1'b1;
                    end
                    flt_addr_d = k_d;
                    in_addr_d  = in_addr_f(r_q, c_q, kr_d, kc_d);
                end
            end
            S_DRAIN: begin
                state_d    = S_OUT;
                out_data_d = sat32_f(acc_d, bias);
                out_addr_d = out_idx_f(r_q, c_q);
            end
            S_OUT: begin
                if (out_ready) begin
                    if (r_q == LAST_RC && c_q == LAST_RC) begin
                        state_d = S_DONE;
                    end else begin
                        if (c_q == LAST_RC) begin
                            c_d = '0;
                            r_d = r_q + 1'b1;
                        end else begin
                            c_d = c_q + 1'b1;
                        end
                        state_d    = S_RUN;
                        acc_d      = '0;
                        k_d        = '0;
                        kr_d       = '0;
                        kc_d       = '0;
                        flt_addr_d = '0;
                        in_addr_d  = in_addr_f(r_d, c_d, '0, '0);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_addr  = in_addr_q;
    assign flt_addr = flt_addr_q;
    assign out_addr = out_addr_q;
    assign out_data = out_data_q;

endmodule
